int_arbiter: RTL and testbench

Multi-source interrupt request arbiter that sits between the peripheral interrupt lines (SPART, SPU, timers) and the CPU interrupt controller. It captures rising edges into pending bits and masks them with a software-written enable register. It then selects one source by fixed priority or round-robin and presents that source's ID and handler vector to the controller over a req/ack/done handshake. It holds the controller to one outstanding interrupt at a time and re-arbitrates only after the controller reports ISR completion.

---
 rtl/int_arbiter.sv | 152 +++++++++++++++
 tb/tb_int_arbiter.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/int_arbiter.sv
// Interrupt request arbiter: edge-captured pending bits, enable mask, fixed-priority or
// round-robin selection, and a one-outstanding req/ack/done handshake to the CPU controller.
module int_arbiter #(
  parameter int          NUM_SRC    = 4,
  parameter logic [31:0] VEC_BASE   = 32'h8,
  parameter logic [31:0] VEC_STRIDE = 32'h4,
  localparam int         ID_W       = $clog2(NUM_SRC)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] src_irq,
  input  logic               cfg_wr,
  input  logic [NUM_SRC-1:0] cfg_en,
  input  logic               cfg_rr,
  output logic               int_req,
  output logic [ID_W-1:0]    int_id,
  output logic [31:0]        int_vec,
  input  logic               int_ack,
  input  logic               int_done,
  output logic [NUM_SRC-1:0] pending,
  output logic               busy
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_REQ     = 2'd1;
  localparam logic [1:0] ST_SERVICE = 2'd2;

  logic [1:0]         state_r;
  logic [NUM_SRC-1:0] src_prev_r;
  logic [NUM_SRC-1:0] enable_r;
  logic               rr_r;
  logic [ID_W-1:0]    last_grant_r;
  logic [NUM_SRC-1:0] edge_s;
  logic [NUM_SRC-1:0] clr_s;
  logic [NUM_SRC-1:0] eligible_s;
  logic [ID_W-1:0]    win_s;
  logic [31:0]        vec_s;

  // Lowest eligible index; scanning downward leaves the lowest hit as the result.
  function automatic logic [ID_W-1:0] pick_fixed(input logic [NUM_SRC-1:0] elig);
    pick_fixed = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (elig[ID_W'(i)]) begin
        pick_fixed = ID_W'(i);
      end
    end
  endfunction

  // First eligible index after the last grant, wrapping at NUM_SRC.
  function automatic logic [ID_W-1:0] pick_rr(input logic [NUM_SRC-1:0] elig,
                                              input logic [ID_W-1:0]    last);
    logic            found;
    int              idx;
    logic [ID_W-1:0] sel;
    pick_rr = '0;
    found   = 1'b0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      idx = int'(last) + k;
      if (idx >= NUM_SRC) begin
        idx = idx - NUM_SRC;
      end
      sel = ID_W'(idx);
      if (!found && elig[sel]) begin
        pick_rr = sel;
        found   = 1'b1;
      end
    end
  endfunction

  // Edge detect, ack-driven clear, and winner/vector selection.
  always_comb begin
    edge_s     = src_irq & ~src_prev_r;
    eligible_s = pending & enable_r;
    clr_s      = '0;
    if (state_r == ST_REQ && int_ack) begin
      clr_s[int_id] = 1'b1;
    end else begin
      clr_s = '0;
    end
    if (rr_r) begin
      win_s = pick_rr(eligible_s, last_grant_r);
    end else begin
      win_s = pick_fixed(eligible_s);
    end
    vec_s = VEC_BASE + 32'(win_s) * VEC_STRIDE;
  end

  // Line history and pending bits; a new edge wins over a same-cycle clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      src_prev_r <= '0;
      pending    <= '0;
    end else begin
      src_prev_r <= src_irq;
      pending    <= (pending & ~clr_s) | edge_s;
    end
  end

  // Software-written enable mask and arbitration mode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      enable_r <= '0;
      rr_r     <= 1'b0;
    end else if (cfg_wr) begin
      enable_r <= cfg_en;
      rr_r     <= cfg_rr;
    end
  end

  // Handshake FSM; id and vector are latched once and held until the next IDLE pass.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      int_req      <= 1'b0;
      int_id       <= '0;
      int_vec      <= VEC_BASE;
      busy         <= 1'b0;
      last_grant_r <= ID_W'(NUM_SRC - 1);
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (|eligible_s) begin
            state_r <= ST_REQ;
            int_req <= 1'b1;
            busy    <= 1'b1;
            int_id  <= win_s;
            int_vec <= vec_s;
          end
        end
        ST_REQ: begin
          if (int_ack) begin
            state_r      <= ST_SERVICE;
            int_req      <= 1'b0;
            last_grant_r <= int_id;
          end
        end
        ST_SERVICE: begin
          if (int_done) begin
            state_r <= ST_IDLE;
            busy    <= 1'b0;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          int_req <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_int_arbiter.sv
// Directed self-checking bench for int_arbiter with NUM_SRC=4, VEC_BASE=8, VEC_STRIDE=4.
module tb_int_arbiter;

  logic       clk, rst, cfg_wr, cfg_rr, int_ack, int_done;
  logic [3:0] src_irq, cfg_en, pending;
  logic       int_req, busy;
  logic [1:0] int_id;
  logic [31:0] int_vec;
  int pass_cnt, total_cnt;
  logic [1:0] exp_rr [0:4] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

  int_arbiter dut (
    .clk(clk), .rst(rst), .src_irq(src_irq), .cfg_wr(cfg_wr), .cfg_en(cfg_en),
    .cfg_rr(cfg_rr), .int_req(int_req), .int_id(int_id), .int_vec(int_vec),
    .int_ack(int_ack), .int_done(int_done), .pending(pending), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_rst();
    rst = 1'b1; src_irq = 4'h0; cfg_wr = 1'b0; cfg_en = 4'h0; cfg_rr = 1'b0;
    int_ack = 1'b0; int_done = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic do_cfg(input logic [3:0] en, input logic rr);
    cfg_en = en; cfg_rr = rr; cfg_wr = 1'b1;
    tick();
    cfg_wr = 1'b0;
  endtask

  task automatic pulse(input logic [3:0] m);
    src_irq = m;
    tick();
    src_irq = 4'h0;
  endtask

  task automatic do_ack();
    int_ack = 1'b1; tick(); int_ack = 1'b0;
  endtask

  task automatic do_done();
    int_done = 1'b1; tick(); int_done = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; src_irq = 4'h0; cfg_wr = 1'b0; cfg_en = 4'h0; cfg_rr = 1'b0;
    int_ack = 1'b0; int_done = 1'b0;
    tick(); tick();
    total_cnt++; if (int_req !== 1'b0) $display("FAIL rst_req got=%0h exp=0", int_req); else pass_cnt++;
    total_cnt++; if (int_id !== 2'd0) $display("FAIL rst_id got=%0h exp=0", int_id); else pass_cnt++;
    total_cnt++; if (int_vec !== 32'h8) $display("FAIL rst_vec got=%0h exp=8", int_vec); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL rst_busy got=%0h exp=0", busy); else pass_cnt++;
    total_cnt++; if (pending !== 4'h0) $display("FAIL rst_pending got=%0h exp=0", pending); else pass_cnt++;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    apply_rst();
    do_cfg(4'hF, 1'b0);
    pulse(4'b0100);
    total_cnt++; if (pending !== 4'b0100) $display("FAIL basic_pend got=%0h exp=4", pending); else pass_cnt++;
    total_cnt++; if (int_req !== 1'b0) $display("FAIL basic_req_t1 got=%0h exp=0", int_req); else pass_cnt++;
    tick();
    total_cnt++; if (int_req !== 1'b1) $display("FAIL basic_req got=%0h exp=1", int_req); else pass_cnt++;
    total_cnt++; if (int_id !== 2'd2) $display("FAIL basic_id got=%0h exp=2", int_id); else pass_cnt++;
    total_cnt++; if (int_vec !== 32'h10) $display("FAIL basic_vec got=%0h exp=10", int_vec); else pass_cnt++;
    total_cnt++; if (busy !== 1'b1) $display("FAIL basic_busy got=%0h exp=1", busy); else pass_cnt++;
    do_ack();
    total_cnt++; if (int_req !== 1'b0) $display("FAIL basic_ack_req got=%0h exp=0", int_req); else pass_cnt++;
    total_cnt++; if (pending !== 4'h0) $display("FAIL basic_ack_pend got=%0h exp=0", pending); else pass_cnt++;
    total_cnt++; if (busy !== 1'b1) $display("FAIL basic_svc_busy got=%0h exp=1", busy); else pass_cnt++;
    do_done();
    total_cnt++; if (busy !== 1'b0) $display("FAIL basic_done_busy got=%0h exp=0", busy); else pass_cnt++;
  endtask

  task automatic test_fixed();
    apply_rst();
    do_cfg(4'hF, 1'b0);
    pulse(4'b1010);
    tick();
    total_cnt++; if (int_id !== 2'd1) $display("FAIL fixed_id1 got=%0h exp=1", int_id); else pass_cnt++;
    total_cnt++; if (int_vec !== 32'hC) $display("FAIL fixed_vec1 got=%0h exp=c", int_vec); else pass_cnt++;
    do_ack();
    total_cnt++; if (pending !== 4'b1000) $display("FAIL fixed_pend got=%0h exp=8", pending); else pass_cnt++;
    do_done();
    total_cnt++; if (int_req !== 1'b0) $display("FAIL fixed_d1_req got=%0h exp=0", int_req); else pass_cnt++;
    tick();
    total_cnt++; if (int_req !== 1'b1) $display("FAIL fixed_d2_req got=%0h exp=1", int_req); else pass_cnt++;
    total_cnt++; if (int_id !== 2'd3) $display("FAIL fixed_id3 got=%0h exp=3", int_id); else pass_cnt++;
    total_cnt++; if (int_vec !== 32'h14) $display("FAIL fixed_vec3 got=%0h exp=14", int_vec); else pass_cnt++;
    do_ack();
    do_done();
  endtask

  task automatic test_round_robin();
    apply_rst();
    do_cfg(4'hF, 1'b1);
    pulse(4'hF);
    tick();
    for (int k = 0; k < 5; k++) begin
      total_cnt++; if (int_req !== 1'b1) $display("FAIL rr_req[%0d] got=%0h exp=1", k, int_req); else pass_cnt++;
      total_cnt++; if (int_id !== exp_rr[k]) $display("FAIL rr_id[%0d] got=%0h exp=%0h", k, int_id, exp_rr[k]); else pass_cnt++;
      do_ack();
      pulse(4'hF);
      do_done();
      tick();
    end
  endtask

  task automatic test_mask();
    apply_rst();
    do_cfg(4'h0, 1'b0);
    pulse(4'b0010);
    tick(); tick();
    total_cnt++; if (pending !== 4'b0010) $display("FAIL mask_pend got=%0h exp=2", pending); else pass_cnt++;
    total_cnt++; if (int_req !== 1'b0) $display("FAIL mask_noreq got=%0h exp=0", int_req); else pass_cnt++;
    do_cfg(4'b0010, 1'b0);
    total_cnt++; if (int_req !== 1'b0) $display("FAIL mask_t1 got=%0h exp=0", int_req); else pass_cnt++;
    tick();
    total_cnt++; if (int_req !== 1'b1) $display("FAIL mask_t2 got=%0h exp=1", int_req); else pass_cnt++;
    total_cnt++; if (int_id !== 2'd1) $display("FAIL mask_id got=%0h exp=1", int_id); else pass_cnt++;
    do_ack();
    do_done();
  endtask

  task automatic test_boundary();
    apply_rst();
    do_cfg(4'hF, 1'b0);
    pulse(4'b0001);
    tick();
    int_ack = 1'b1; src_irq = 4'b0001;
    tick();
    int_ack = 1'b0; src_irq = 4'h0;
    total_cnt++; if (pending !== 4'b0001) $display("FAIL bnd_setwins got=%0h exp=1", pending); else pass_cnt++;
    total_cnt++; if (int_req !== 1'b0) $display("FAIL bnd_ack_req got=%0h exp=0", int_req); else pass_cnt++;
    do_done();
    tick();
    total_cnt++; if (int_req !== 1'b1) $display("FAIL bnd_rereq got=%0h exp=1", int_req); else pass_cnt++;
    do_done();
    total_cnt++; if (int_req !== 1'b1) $display("FAIL bnd_done_in_req got=%0h exp=1", int_req); else pass_cnt++;
    total_cnt++; if (busy !== 1'b1) $display("FAIL bnd_done_busy got=%0h exp=1", busy); else pass_cnt++;
    do_ack();
    do_done();
    // Level held high for 10 cycles should yield exactly one service.
    src_irq = 4'b0001;
    tick(); tick();
    total_cnt++; if (int_req !== 1'b1) $display("FAIL bnd_lvl_req got=%0h exp=1", int_req); else pass_cnt++;
    do_ack();
    do_done();
    for (int k = 0; k < 6; k++) tick();
    total_cnt++; if (int_req !== 1'b0) $display("FAIL bnd_lvl_once got=%0h exp=0", int_req); else pass_cnt++;
    total_cnt++; if (pending !== 4'h0) $display("FAIL bnd_lvl_pend got=%0h exp=0", pending); else pass_cnt++;
    src_irq = 4'h0;
    tick();
  endtask

  task automatic test_reset_mid();
    apply_rst();
    do_cfg(4'hF, 1'b0);
    pulse(4'b0101);
    tick();
    do_ack();
    pulse(4'b0001);
    total_cnt++; if (pending !== 4'b0101) $display("FAIL rmid_pre_pend got=%0h exp=5", pending); else pass_cnt++;
    rst = 1'b1;
    #1;
    total_cnt++; if (pending !== 4'h0) $display("FAIL rmid_pend got=%0h exp=0", pending); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL rmid_busy got=%0h exp=0", busy); else pass_cnt++;
    total_cnt++; if (int_req !== 1'b0) $display("FAIL rmid_req got=%0h exp=0", int_req); else pass_cnt++;
    total_cnt++; if (int_vec !== 32'h8) $display("FAIL rmid_vec got=%0h exp=8", int_vec); else pass_cnt++;
    tick();
    rst = 1'b0;
    pulse(4'b0101);
    tick(); tick();
    total_cnt++; if (int_req !== 1'b0) $display("FAIL rmid_masked got=%0h exp=0", int_req); else pass_cnt++;
    do_cfg(4'hF, 1'b0);
    tick();
    total_cnt++; if (int_req !== 1'b1) $display("FAIL rmid_reen_req got=%0h exp=1", int_req); else pass_cnt++;
    total_cnt++; if (int_id !== 2'd0) $display("FAIL rmid_reen_id got=%0h exp=0", int_id); else pass_cnt++;
  endtask

  initial begin
    pass_cnt = 0;
    total_cnt = 0;
    test_reset();
    test_basic();
    test_fixed();
    test_round_robin();
    test_mask();
    test_boundary();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
